// File: rtl/pipe_sched_pkg.sv
// Shared control-bit positions, stage record type and helpers for the pipe_sched block.
// Pure declarations; no timing or flow control lives here.
package pipe_sched_pkg;

   localparam int LD_DATA  = 0;
   localparam int LD_COEFF = 1;
   localparam int MULT     = 2;
   localparam int ADD      = 3;
   localparam int WRITE    = 4;
   localparam int NUM_CTRL = 5;

   typedef logic [NUM_CTRL-1:0] ctrl_t;

   typedef struct packed {
      logic  vld;
      ctrl_t ctrl;
   } stg_t;

   // Only the bits that touch memory survive; MULT and ADD never reserve a slot.
   function automatic ctrl_t mem_mask(input ctrl_t ctrl);
      ctrl_t m;
      m           = '0;
      m[LD_DATA]  = ctrl[LD_DATA];
      m[LD_COEFF] = ctrl[LD_COEFF];
      m[WRITE]    = ctrl[WRITE];
      return m;
   endfunction

   function automatic int ofs_max(input int a, input int b, input int c, input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

endpackage

// File: rtl/pipe_sched_if.sv
// Fetch-side handshake, stage strobes and statistics of pipe_sched.
// master = instruction fetch / observer, slave = the scheduler itself.
interface pipe_sched_if #(
   parameter int INST_W = 8,
   parameter int CNT_W  = 16
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [INST_W-1:0] inst;
   logic              load_data;
   logic              load_coeff;
   logic              mult;
   logic              add;
   logic              write;
   logic              busy;
   logic              collision;
   logic [CNT_W-1:0]  issued_cnt;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output flush, in_valid, inst,
      input  in_ready, load_data, load_coeff, mult, add, write, busy, collision,
      input  issued_cnt, stall_cnt
   );

   modport slave (
      input  flush, in_valid, inst,
      output in_ready, load_data, load_coeff, mult, add, write, busy, collision,
      output issued_cnt, stall_cnt
   );
endinterface

// File: rtl/pipe_sched_scoreboard.sv
// Memory-slot reservation tracker: combinational conflict for the offered instruction, 1-cycle update.
// Needs DEPTH >= 2; flush and reset drop every reservation on the next edge.
module pipe_sched_scoreboard
   import pipe_sched_pkg::*;
#(
   parameter int DEPTH        = 5,
   parameter int OFS_LD_DATA  = 1,
   parameter int OFS_LD_COEFF = 2,
   parameter int OFS_MULT     = 3,
   parameter int OFS_ADD      = 4,
   parameter int OFS_WRITE    = 5
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  flush_i,
   input  logic  issue_i,
   input  ctrl_t mem_i,
   output logic  conflict_o
);

   logic [DEPTH:1] need;
   // resv_q[k]: a memory strobe fires from stage k this cycle. Stage 1 is never
   // compared (it moves on before a new issue can land), so it is not stored.
   logic [DEPTH:2] resv_q;
   logic [DEPTH:2] resv_d;

   always_comb begin
      need = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         need[k] = (k == OFS_LD_DATA  && mem_i[LD_DATA])
                || (k == OFS_LD_COEFF && mem_i[LD_COEFF])
                || (k == OFS_MULT     && mem_i[MULT])
                || (k == OFS_ADD      && mem_i[ADD])
                || (k == OFS_WRITE    && mem_i[WRITE]);
      end
   end

   // A candidate reaching stage k next cycle meets whatever is at stage k+1 now.
   assign conflict_o = |(need[DEPTH-1:1] & resv_q);

   always_comb begin
      resv_d = (resv_q >> 1) | (need[DEPTH:2] & {(DEPTH-1){issue_i}});
      if (flush_i) resv_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) resv_q <= '0;
      else       resv_q <= resv_d;
   end

endmodule

// File: rtl/pipe_sched.sv
// Hazard-aware instruction shift pipeline: strobe at offset k fires k cycles after issue; in_ready drops
// while a memory slot clashes, on flush and in reset. PIPE_SCHED_STATS_EN enables the statistics counters.
module pipe_sched
   import pipe_sched_pkg::*;
#(
   parameter int INST_W       = 8,
   parameter int OFS_LD_DATA  = 1,
   parameter int OFS_LD_COEFF = 2,
   parameter int OFS_MULT     = 3,
   parameter int OFS_ADD      = 4,
   parameter int OFS_WRITE    = 5,
   parameter int CNT_W        = 16
) (
   input logic         clk,
   input logic         reset,
   pipe_sched_if.slave io
);

   localparam int DEPTH = ofs_max(OFS_LD_DATA, OFS_LD_COEFF, OFS_MULT, OFS_ADD, OFS_WRITE);

   stg_t  stg_q [1:DEPTH];
   stg_t  stg_d [1:DEPTH];
   ctrl_t ctrl;
   ctrl_t mem;
   logic  conflict;
   logic  issue;
   logic  any_vld;
   logic [1:0] n_mem;

   assign ctrl        = io.inst[NUM_CTRL-1:0];
   assign mem         = mem_mask(ctrl);
   assign io.in_ready = !reset && !io.flush && !conflict;
   assign issue       = io.in_valid && io.in_ready;

   generate
      if (INST_W > NUM_CTRL) begin : g_hi_bits
         logic unused_hi;
         assign unused_hi = ^io.inst[INST_W-1:NUM_CTRL];
      end
   endgenerate

   pipe_sched_scoreboard #(
      .DEPTH        (DEPTH),
      .OFS_LD_DATA  (OFS_LD_DATA),
      .OFS_LD_COEFF (OFS_LD_COEFF),
      .OFS_MULT     (OFS_MULT),
      .OFS_ADD      (OFS_ADD),
      .OFS_WRITE    (OFS_WRITE)
   ) u_sb (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (io.flush),
      .issue_i    (issue),
      .mem_i      (mem),
      .conflict_o (conflict)
   );

   always_comb begin
      stg_d[1] = '{vld: issue, ctrl: ctrl};
      for (int k = 2; k <= DEPTH; k++) stg_d[k] = stg_q[k-1];
      if (io.flush) begin
         for (int k = 1; k <= DEPTH; k++) stg_d[k].vld = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= DEPTH; k++) stg_q[k] <= '0;
      end else begin
         for (int k = 1; k <= DEPTH; k++) stg_q[k] <= stg_d[k];
      end
   end

   assign io.load_data  = stg_q[OFS_LD_DATA].vld  & stg_q[OFS_LD_DATA].ctrl[LD_DATA];
   assign io.load_coeff = stg_q[OFS_LD_COEFF].vld & stg_q[OFS_LD_COEFF].ctrl[LD_COEFF];
   assign io.mult       = stg_q[OFS_MULT].vld     & stg_q[OFS_MULT].ctrl[MULT];
   assign io.add        = stg_q[OFS_ADD].vld      & stg_q[OFS_ADD].ctrl[ADD];
   assign io.write      = stg_q[OFS_WRITE].vld    & stg_q[OFS_WRITE].ctrl[WRITE];

   always_comb begin
      any_vld = 1'b0;
      for (int k = 1; k <= DEPTH; k++) any_vld = any_vld | stg_q[k].vld;
   end
   assign io.busy = any_vld;

   assign n_mem        = 2'(io.load_data) + 2'(io.load_coeff) + 2'(io.write);
   assign io.collision = (n_mem > 2'd1);

`ifdef PIPE_SCHED_STATS_EN
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      issued_d = issued_q;
      stall_d  = stall_q;
      if (issue) issued_d = issued_q + ONE;
      if (io.in_valid && !io.in_ready && !io.flush) stall_d = stall_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         issued_q <= issued_d;
         stall_q  <= stall_d;
      end
   end

   assign io.issued_cnt = issued_q;
   assign io.stall_cnt  = stall_q;
`else
   assign io.issued_cnt = '0;
   assign io.stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Scoreboard bench for pipe_sched: the driver predicts in_ready and per-cycle strobes from an
// absolute-cycle memory-slot model; a negedge monitor pops and compares what the DUT presents.
module tb_pipe_sched;

   localparam int MAXC = 12000;
   localparam int OFS [5] = '{1, 2, 3, 4, 5};

   logic clk;
   logic rst;

   pipe_sched_if #(.INST_W(8), .CNT_W(16)) io ();

   pipe_sched dut (
      .clk   (clk),
      .reset (rst),
      .io    (io.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n;
   int n_cmp;
   int n_err;
   bit [5:0] exp_out [0:MAXC];
   bit       mem_busy [0:MAXC];
   bit       exp_rdy_q [$];
   logic [15:0] m_issued;
   logic [15:0] m_stall;

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, want, n);
      end
   endfunction

   function automatic logic [15:0] cexp(input logic [15:0] v);
`ifdef PIPE_SCHED_STATS_EN
      return v;
`else
      return v & 16'h0000;
`endif
   endfunction

   function automatic bit mem_ok(input logic [7:0] ins);
      bit ok;
      ok = 1'b1;
      if (ins[0] && mem_busy[n + OFS[0]]) ok = 1'b0;
      if (ins[1] && mem_busy[n + OFS[1]]) ok = 1'b0;
      if (ins[4] && mem_busy[n + OFS[4]]) ok = 1'b0;
      return ok;
   endfunction

   // One clock: drive inputs for edge n+1, predict its effect, advance.
   task automatic step(input bit v, input logic [7:0] ins, input bit fl, input bit rs, output bit iss);
      bit rdy;
      rst         = rs;
      io.flush    = fl;
      io.in_valid = v;
      io.inst     = ins;
      rdy = !rs && !fl && mem_ok(ins);
      if (v) exp_rdy_q.push_back(rdy);
      iss = v && rdy;
      if (rs || fl) begin
         for (int c = n + 1; c <= n + 6; c++) begin
            exp_out[c]  = '0;
            mem_busy[c] = 1'b0;
         end
      end
      if (rs) begin
         m_issued = '0;
         m_stall  = '0;
      end else if (!fl) begin
         if (iss) begin
            m_issued = m_issued + 16'd1;
            for (int b = 0; b < 5; b++) begin
               if (ins[b]) exp_out[n + OFS[b]][b] = 1'b1;
            end
            if (ins[0]) mem_busy[n + OFS[0]] = 1'b1;
            if (ins[1]) mem_busy[n + OFS[1]] = 1'b1;
            if (ins[4]) mem_busy[n + OFS[4]] = 1'b1;
            for (int c = n + 1; c <= n + 5; c++) exp_out[c][5] = 1'b1;
         end else if (v) begin
            m_stall = m_stall + 16'd1;
         end
      end
      @(posedge clk);
      n++;
      #1;
   endtask

   task automatic idle(input int cnt);
      bit d;
      for (int i = 0; i < cnt; i++) step(1'b0, 8'h00, 1'b0, 1'b0, d);
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_issued"}, {16'h0, io.issued_cnt}, {16'h0, cexp(m_issued)});
      chk({tag, "_stall"},  {16'h0, io.stall_cnt},  {16'h0, cexp(m_stall)});
   endtask

   // Monitor: compares every presented output against the scoreboard.
   always @(negedge clk) begin
      if (n > 0) begin
         chk("strobes_busy", {26'h0, io.busy, io.write, io.add, io.mult, io.load_coeff, io.load_data},
             {26'h0, exp_out[n]});
         chk("collision", {31'h0, io.collision}, 32'h0);
         if (io.in_valid) begin
            if (exp_rdy_q.size() == 0) begin
               chk("rdy_q_underflow", 32'h1, 32'h0);
            end else begin
               chk("in_ready", {31'h0, io.in_ready}, {31'h0, exp_rdy_q.pop_front()});
            end
         end
      end
   end

   initial begin
      bit iss;
      bit holding;
      int tries;
      logic [7:0] r_ins;
      n = 0; n_cmp = 0; n_err = 0;
      m_issued = '0; m_stall = '0;
      rst = 1'b1; io.flush = 1'b0; io.in_valid = 1'b0; io.inst = 8'h00;
      @(posedge clk);
      n = 1;
      #1;

      // Reset held with an offer present: in_ready must stay low.
      step(1'b1, 8'h04, 1'b0, 1'b1, iss);
      step(1'b1, 8'h1F, 1'b0, 1'b1, iss);
      chk_cnt("reset");

      // Mult-only stream: no stalls, 1/cycle.
      for (int i = 0; i < 10; i++) step(1'b1, 8'h04, 1'b0, 1'b0, iss);
      idle(6);
      chk_cnt("mult");
      chk("mult_issued_hand", {16'h0, io.issued_cnt}, {16'h0, cexp(16'd10)});

      // LD_DATA|LD_COEFF held: issue every other cycle.
      for (int i = 0; i < 7; i++) step(1'b1, 8'h03, 1'b0, 1'b0, iss);
      idle(6);
      chk_cnt("ld2");
      chk("ld2_stall_hand", {16'h0, io.stall_cnt}, {16'h0, cexp(16'd3)});

      // Write at edge e, load_data offered for edge e+4 clashes and waits one cycle.
      step(1'b1, 8'h10, 1'b0, 1'b0, iss);
      chk("write_issue", {31'h0, iss}, 32'h1);
      idle(3);
      tries = 0;
      do begin
         step(1'b1, 8'h01, 1'b0, 1'b0, iss);
         tries++;
      end while (!iss && tries < 10);
      chk("ld_after_write_tries", tries, 2);
      idle(6);
      chk_cnt("wr_ld");

      // Full instruction, flush two cycles later, immediate re-issue.
      step(1'b1, 8'h1F, 1'b0, 1'b0, iss);
      step(1'b0, 8'h00, 1'b0, 1'b0, iss);
      step(1'b1, 8'h1F, 1'b1, 1'b0, iss);
      step(1'b1, 8'h1F, 1'b0, 1'b0, iss);
      chk("reissue_after_flush", {31'h0, iss}, 32'h1);
      idle(6);
      chk_cnt("flush");

      // Reset while the pipe is full.
      for (int i = 0; i < 6; i++) step(1'b1, 8'h0C, 1'b0, 1'b0, iss);
      step(1'b0, 8'h00, 1'b0, 1'b1, iss);
      chk("busy_after_reset", {31'h0, io.busy}, 32'h0);
      chk_cnt("midreset");
      idle(2);

      // Random traffic, offer rate ~70 %, inst held until accepted.
      holding = 1'b0;
      r_ins = 8'h00;
      for (int i = 0; i < 10000; i++) begin
         if (!holding && $urandom_range(0, 99) < 70) begin
            r_ins   = 8'($urandom_range(0, 255));
            holding = 1'b1;
         end
         step(holding, r_ins, 1'b0, 1'b0, iss);
         if (iss) holding = 1'b0;
      end
      idle(8);
      chk_cnt("random");
      chk("rdy_q_empty", exp_rdy_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
